// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg
//   Parametrised N-input multiplexer with a single-entry registered output
//   stage and a valid/ready handshake on both sides. The selected word is
//   captured on an accepting edge and held until the consumer takes it, so
//   the block can sit between datapath stages and pass back-pressure upstream.
//   With NUM_INPUTS=4, SEL_WIDTH=2 the data mapping matches the old
//   combinational 4-to-1 mux, plus one cycle of latency.
//
// Parameters
//   WORD_LENGTH : width of each channel and of MUX_Output
//   NUM_INPUTS  : number of channels (2..64)
//   SEL_WIDTH   : selector width, 2**SEL_WIDTH >= NUM_INPUTS
//
// Ports
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   Selector    : channel index for the current transfer
//   MUX_Data    : packed channels, channel i at [i*WORD_LENGTH +: WORD_LENGTH]
//   In_Valid    : producer presents Selector/MUX_Data
//   In_Ready    : block can accept this cycle (!Out_Valid || Out_Ready)
//   MUX_Output  : registered selected word
//   Out_Valid   : MUX_Output holds an unconsumed word
//   Out_Ready   : consumer accepts MUX_Output this cycle
//   Sel_Error   : the held word came from an out-of-range selector
//
// Optional feature (macro MUX_N_SEL_ERROR_COUNT_EN)
//   Error_Count : 8-bit saturating count of accepted out-of-range transfers
//   Error_Clear : synchronous clear of Error_Count, wins over an increment

module mux_n_to_1_reg #(
  parameter int WORD_LENGTH = 32,
  parameter int NUM_INPUTS  = 4,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [SEL_WIDTH-1:0]              Selector,
  input  logic [NUM_INPUTS*WORD_LENGTH-1:0] MUX_Data,
  input  logic                              In_Valid,
  output logic                              In_Ready,
  output logic [WORD_LENGTH-1:0]            MUX_Output,
  output logic                              Out_Valid,
  input  logic                              Out_Ready,
`ifdef MUX_N_SEL_ERROR_COUNT_EN
  input  logic                              Error_Clear,
  output logic [7:0]                        Error_Count,
`endif
  output logic                              Sel_Error
);

  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   sel_err_q, sel_err_d;
  logic [WORD_LENGTH-1:0] sel_word;
  logic                   sel_in_range;
  logic                   accept;

  // Space is available when the register is empty or is being drained this
  // cycle; deliberately independent of In_Valid so no comb loop can form.
  assign In_Ready = !valid_q || Out_Ready;
  assign accept   = In_Valid && In_Ready;

  // Channel selection. Selectors with no matching channel leave the word at
  // zero and are flagged as out of range; when every selector code maps to a
  // channel the flag can never rise.
  always_comb begin
    sel_word     = '0;
    sel_in_range = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (Selector == SEL_WIDTH'(i)) begin
        sel_word     = MUX_Data[i*WORD_LENGTH +: WORD_LENGTH];
        sel_in_range = 1'b1;
      end
    end
  end

  // Next state of the output register. An accept always reloads data and
  // error flag together so they share one lifetime; a consume without an
  // accept only drops the valid bit and leaves the last word visible.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    sel_err_d = sel_err_q;
    if (accept) begin
      data_d    = sel_word;
      valid_d   = 1'b1;
      sel_err_d = !sel_in_range;
    end else if (valid_q && Out_Ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign MUX_Output = data_q;
  assign Out_Valid  = valid_q;
  assign Sel_Error  = sel_err_q;

`ifdef MUX_N_SEL_ERROR_COUNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted out-of-range transfers; clear has priority.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (Error_Clear) begin
      err_cnt_d = 8'd0;
    end else if (accept && !sel_in_range && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign Error_Count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Testbench for mux_n_to_1_reg. Two instances share all stimulus: dut_a has
// four channels (every selector valid), dut_b has three channels so that
// Selector=3 is out of range. A fixed vector table covers the directed
// scenarios, then a randomized phase is checked against a slot-based model.

module tb_mux_n_to_1_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [1:0]   selector;
  logic [4*W-1:0] mux_data;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, sel_error_a;
  logic [W-1:0] mux_output_a;
  logic         in_ready_b, out_valid_b, sel_error_b;
  logic [W-1:0] mux_output_b;
`ifdef MUX_N_SEL_ERROR_COUNT_EN
  logic         error_clear;
  logic [7:0]   error_count_a, error_count_b;
`endif

  mux_n_to_1_reg #(.WORD_LENGTH(W), .NUM_INPUTS(4), .SEL_WIDTH(2)) dut_a (
    .clk(clk), .reset(reset), .Selector(selector), .MUX_Data(mux_data),
    .In_Valid(in_valid), .In_Ready(in_ready_a), .MUX_Output(mux_output_a),
    .Out_Valid(out_valid_a), .Out_Ready(out_ready),
`ifdef MUX_N_SEL_ERROR_COUNT_EN
    .Error_Clear(error_clear), .Error_Count(error_count_a),
`endif
    .Sel_Error(sel_error_a)
  );

  mux_n_to_1_reg #(.WORD_LENGTH(W), .NUM_INPUTS(3), .SEL_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .Selector(selector), .MUX_Data(mux_data[3*W-1:0]),
    .In_Valid(in_valid), .In_Ready(in_ready_b), .MUX_Output(mux_output_b),
    .Out_Valid(out_valid_b), .Out_Ready(out_ready),
`ifdef MUX_N_SEL_ERROR_COUNT_EN
    .Error_Clear(error_clear), .Error_Count(error_count_b),
`endif
    .Sel_Error(sel_error_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the output stage is a one-deep slot (queue). Expected
  // visible outputs are the last words loaded, which persist after a pop.
  int           slot_q[$];
  logic [W-1:0] m_out_a, m_out_b;
  logic         m_err_b;
  int           m_cnt_b;

  function automatic logic [W-1:0] chan(input int i);
    return mux_data[i*W +: W];
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic modelStep();
    bit rdy;
    bit acc;
    int s;
    if (reset) begin
      slot_q.delete();
      m_out_a = '0;
      m_out_b = '0;
      m_err_b = 1'b0;
      m_cnt_b = 0;
    end else begin
      rdy = (slot_q.size() == 0) || out_ready;
      acc = in_valid && rdy;
      s   = int'(selector);
      if (slot_q.size() > 0 && out_ready) void'(slot_q.pop_front());
      if (acc) begin
        slot_q.push_back(s);
        m_out_a = chan(s);
        m_out_b = (s < 3) ? chan(s) : '0;
        m_err_b = (s >= 3);
        if (s >= 3 && m_cnt_b < 255) m_cnt_b++;
      end
`ifdef MUX_N_SEL_ERROR_COUNT_EN
      if (error_clear) m_cnt_b = 0;
`endif
    end
  endtask

  // Drive one cycle's inputs, optionally check In_Ready before the edge,
  // then clock the DUTs and the model together.
  task automatic applyStimulus(input bit rst, input bit iv, input logic [1:0] sel,
                               input bit ordy, input bit chk_rdy, input bit exp_rdy,
                               input string tag);
    reset     = rst;
    in_valid  = iv;
    selector  = sel;
    out_ready = ordy;
    #1;
    if (chk_rdy) begin
      check({tag, " in_ready_a"}, 32'(in_ready_a), 32'(exp_rdy));
      check({tag, " in_ready_b"}, 32'(in_ready_b), 32'(exp_rdy));
    end
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] exp_a, input bit exp_v,
                             input logic [W-1:0] exp_b, input bit exp_eb);
    check({tag, " out_a"},   mux_output_a,        exp_a);
    check({tag, " valid_a"}, 32'(out_valid_a),    32'(exp_v));
    check({tag, " err_a"},   32'(sel_error_a),    32'd0);
    check({tag, " out_b"},   mux_output_b,        exp_b);
    check({tag, " valid_b"}, 32'(out_valid_b),    32'(exp_v));
    check({tag, " err_b"},   32'(sel_error_b),    32'(exp_eb));
  endtask

  typedef struct {
    bit         rst;
    bit         iv;
    logic [1:0] sel;
    bit         ordy;
    bit         chk_rdy;
    bit         exp_rdy;
    logic [31:0] exp_a;
    bit         exp_v;
    logic [31:0] exp_b;
    bit         exp_eb;
  } vec_t;

  localparam logic [31:0] C0 = 32'h11111111;
  localparam logic [31:0] C1 = 32'h22222222;
  localparam logic [31:0] C2 = 32'h33333333;
  localparam logic [31:0] C3 = 32'h44444444;

  vec_t vecs[17];

  initial begin
    // rst iv sel ordy chk exp_rdy | after edge: out_a valid out_b err_b
    vecs[0]  = '{1, 1, 2'd2, 1, 0, 1, 32'h0, 0, 32'h0, 0}; // reset, X before
    vecs[1]  = '{1, 1, 2'd2, 1, 1, 1, 32'h0, 0, 32'h0, 0}; // reset held
    vecs[2]  = '{0, 1, 2'd2, 1, 1, 1, C2,    1, C2,    0}; // basic select
    vecs[3]  = '{0, 1, 2'd0, 1, 1, 1, C0,    1, C0,    0}; // streaming
    vecs[4]  = '{0, 1, 2'd1, 1, 1, 1, C1,    1, C1,    0};
    vecs[5]  = '{0, 1, 2'd2, 1, 1, 1, C2,    1, C2,    0};
    vecs[6]  = '{0, 1, 2'd3, 1, 1, 1, C3,    1, 32'h0, 1}; // out of range on b
    vecs[7]  = '{0, 1, 2'd0, 1, 1, 1, C0,    1, C0,    0}; // error clears
    vecs[8]  = '{0, 1, 2'd1, 1, 1, 1, C1,    1, C1,    0}; // back-pressure
    vecs[9]  = '{0, 1, 2'd3, 0, 1, 0, C1,    1, C1,    0};
    vecs[10] = '{0, 1, 2'd3, 0, 1, 0, C1,    1, C1,    0};
    vecs[11] = '{0, 1, 2'd3, 0, 1, 0, C1,    1, C1,    0};
    vecs[12] = '{0, 1, 2'd3, 1, 1, 1, C3,    1, 32'h0, 1}; // release
    vecs[13] = '{0, 0, 2'd0, 1, 1, 1, C3,    0, 32'h0, 1}; // drain, word kept
    vecs[14] = '{0, 1, 2'd1, 0, 1, 1, C1,    1, C1,    0}; // fill, stall
    vecs[15] = '{1, 1, 2'd2, 0, 1, 0, 32'h0, 0, 32'h0, 0}; // reset mid-op
    vecs[16] = '{0, 0, 2'd0, 1, 1, 1, 32'h0, 0, 32'h0, 0}; // idle after reset

`ifdef MUX_N_SEL_ERROR_COUNT_EN
    error_clear = 1'b0;
`endif
    mux_data = {C3, C2, C1, C0};

    for (int i = 0; i < 17; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].ordy,
                    vecs[i].chk_rdy, vecs[i].exp_rdy, tag);
      checkOutput(tag, vecs[i].exp_a, vecs[i].exp_v, vecs[i].exp_b, vecs[i].exp_eb);
    end

    // Randomized traffic with fresh data every cycle and occasional resets.
    for (int n = 0; n < 400; n++) begin
      bit rst, iv, ordy, erdy;
      logic [1:0] sel;
      mux_data = {$urandom, $urandom, $urandom, $urandom};
      rst  = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      sel  = 2'($urandom_range(0, 3));
      erdy = (slot_q.size() == 0) || ordy;
      applyStimulus(rst, iv, sel, ordy, 1'b1, erdy, "rand");
      checkOutput("rand", m_out_a, slot_q.size() > 0, m_out_b, m_err_b);
`ifdef MUX_N_SEL_ERROR_COUNT_EN
      check("rand cnt_b", 32'(error_count_b), 32'(m_cnt_b));
`endif
    end

`ifdef MUX_N_SEL_ERROR_COUNT_EN
    // Saturating error counter: one bad transfer, 300 more, then clear.
    mux_data = {C3, C2, C1, C0};
    applyStimulus(1, 0, 2'd0, 1, 0, 1, "cnt_rst");
    check("cnt after reset", 32'(error_count_b), 32'd0);
    applyStimulus(0, 1, 2'd3, 1, 1, 1, "cnt_one");
    check("cnt one", 32'(error_count_b), 32'd1);
    for (int k = 0; k < 300; k++) applyStimulus(0, 1, 2'd3, 1, 0, 1, "cnt_sat");
    check("cnt saturate", 32'(error_count_b), 32'd255);
    check("cnt_a stays 0", 32'(error_count_a), 32'd0);
    error_clear = 1'b1;
    applyStimulus(0, 1, 2'd3, 1, 1, 1, "cnt_clr");
    error_clear = 1'b0;
    check("cnt clear wins", 32'(error_count_b), 32'd0);
    check("cnt model", 32'(m_cnt_b), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
